// File: rtl/sine_measure_ctrl.sv
// Sequencer for one oscillator measurement: reset the oscillator, wait for it to settle,
// then record the peaks and the period between the first two rising threshold crossings.
module sine_measure_ctrl #(
  parameter int RST_CYCLES    = 2,
  parameter int SETTLE_CYCLES = 256,
  parameter int WINDOW        = 1792,
  parameter int MID           = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  amp_code,
  output logic [7:0]  osc_v_in,
  output logic        osc_rst,
  input  logic [7:0]  osc_v_out,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  peak_max,
  output logic [7:0]  peak_min,
  output logic [10:0] period,
  output logic [2:0]  state_dbg
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_OSC_RST = 3'd1;
  localparam logic [2:0] S_SETTLE  = 3'd2;
  localparam logic [2:0] S_MEASURE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [15:0] RST_LAST    = 16'(RST_CYCLES - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] WIN_LAST    = 16'(WINDOW - 1);
  localparam logic [7:0]  MID_CODE    = 8'(MID);

  logic [2:0]  state;
  logic [15:0] cnt;
  logic [7:0]  prev;
  logic [1:0]  cross_cnt;
  logic [10:0] first_idx;
  logic        rising;
  logic [1:0]  cross_next;

  // start/busy handshake: start is a request sampled only while busy=0 (IDLE);
  // it is dropped, not queued, at any other time. done pulses once per accepted start.
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign osc_rst   = rst | (state == S_OSC_RST);
  assign state_dbg = state;

  // Index 0 only seeds prev, so it can never be a crossing.
  always_comb begin
    rising     = (cnt != 16'd0) && (prev < MID_CODE) && (osc_v_out >= MID_CODE);
    cross_next = cross_cnt;
    if (rising && cross_cnt != 2'd2) cross_next = cross_cnt + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      prev      <= '0;
      cross_cnt <= '0;
      first_idx <= '0;
      osc_v_in  <= '0;
      err       <= 1'b0;
      peak_max  <= '0;
      peak_min  <= '0;
      period    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_OSC_RST;
            cnt       <= '0;
            cross_cnt <= '0;
            osc_v_in  <= amp_code;
            err       <= 1'b0;
            peak_max  <= '0;
            peak_min  <= '0;
            period    <= '0;
          end
        end
        S_OSC_RST: begin
          if (cnt == RST_LAST) begin
            cnt   <= '0;
            state <= (SETTLE_CYCLES == 0) ? S_MEASURE : S_SETTLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            cnt   <= '0;
            state <= S_MEASURE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_MEASURE: begin
          prev      <= osc_v_out;
          cross_cnt <= cross_next;
          if (cnt == 16'd0) begin
            peak_max <= osc_v_out;
            peak_min <= osc_v_out;
          end else begin
            if (osc_v_out > peak_max) peak_max <= osc_v_out;
            if (osc_v_out < peak_min) peak_min <= osc_v_out;
          end
          if (rising && cross_cnt == 2'd0) first_idx <= cnt[10:0];
          if (rising && cross_cnt == 2'd1) period <= cnt[10:0] - first_idx;
          if (cnt == WIN_LAST) begin
            cnt   <= '0;
            err   <= (cross_next < 2'd2);
            state <= S_DONE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sine_measure_ctrl.sv
// Bench for sine_measure_ctrl: the bench plays the oscillator, driving osc_v_out per
// measurement index, and predicts results by scanning the same sample table.
module tb_sine_measure_ctrl;

  localparam int RST_C = 2;
  localparam int SET_C = 4;
  localparam int WIN   = 64;
  localparam int MIDV  = 128;
  localparam int T_MEAS = 1 + RST_C + SET_C;      // first MEASURE cycle after start in cycle 0
  localparam int T_DONE = T_MEAS + WIN;           // 71

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  amp_code = '0;
  logic [7:0]  osc_v_in;
  logic        osc_rst;
  logic [7:0]  osc_v_out = '0;
  logic        busy, done, err;
  logic [7:0]  peak_max, peak_min;
  logic [10:0] period;
  logic [2:0]  state_dbg;

  int n_pass = 0;
  int n_total = 0;
  logic [7:0] pat [WIN];
  logic [7:0] exp_vin = '0;

  sine_measure_ctrl #(
    .RST_CYCLES(RST_C), .SETTLE_CYCLES(SET_C), .WINDOW(WIN), .MID(MIDV)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .amp_code(amp_code),
    .osc_v_in(osc_v_in), .osc_rst(osc_rst), .osc_v_out(osc_v_out),
    .busy(busy), .done(done), .err(err), .peak_max(peak_max),
    .peak_min(peak_min), .period(period), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  task automatic model(output logic [7:0] mx, output logic [7:0] mn,
                       output logic [10:0] per, output logic e);
    int xs[$];
    mx = pat[0];
    mn = pat[0];
    for (int i = 1; i < WIN; i++) begin
      if (pat[i] > mx) mx = pat[i];
      if (pat[i] < mn) mn = pat[i];
      if (int'(pat[i-1]) < MIDV && int'(pat[i]) >= MIDV) xs.push_back(i);
    end
    e   = (xs.size() < 2);
    per = (xs.size() < 2) ? 11'd0 : 11'(xs[1] - xs[0]);
  endtask

  // ---------------- driver + inline checks for one full run ----------------
  // Start is applied in cycle 0; extra start pulses at pa/pb/pc (use -1 for none).
  task automatic run(input string tag, input logic [7:0] amp, input int pa, input int pb, input int pc);
    logic [7:0]  e_max, e_min;
    logic [10:0] e_per;
    logic        e_err;
    model(e_max, e_min, e_per, e_err);
    for (int c = 0; c <= T_DONE + 1; c++) begin
      n_total++;
      if (osc_v_in !== ((c >= 1) ? amp : exp_vin))
        $display("FAIL %s osc_v_in cyc=%0d got=%0d want=%0d", tag, c, osc_v_in, (c >= 1) ? amp : exp_vin);
      else n_pass++;
      n_total++;
      if (busy !== (c >= 1 && c <= T_DONE))
        $display("FAIL %s busy cyc=%0d got=%b", tag, c, busy);
      else n_pass++;
      n_total++;
      if (osc_rst !== (c >= 1 && c <= RST_C))
        $display("FAIL %s osc_rst cyc=%0d got=%b", tag, c, osc_rst);
      else n_pass++;
      n_total++;
      if (done !== (c == T_DONE))
        $display("FAIL %s done cyc=%0d got=%b", tag, c, done);
      else n_pass++;
      if (c >= T_DONE) begin
        n_total++;
        if ({peak_max, peak_min, period, err} !== {e_max, e_min, e_per, e_err})
          $display("FAIL %s results cyc=%0d got max=%0d min=%0d per=%0d err=%b want max=%0d min=%0d per=%0d err=%b",
                   tag, c, peak_max, peak_min, period, err, e_max, e_min, e_per, e_err);
        else n_pass++;
      end
      if (c <= T_DONE) begin
        start     = (c == 0 || c == pa || c == pb || c == pc);
        amp_code  = (c == 0) ? amp : 8'($urandom);
        osc_v_out = (c >= T_MEAS && c < T_DONE) ? pat[c - T_MEAS] : 8'($urandom);
        step();
      end
    end
    start   = 1'b0;
    exp_vin = amp;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      n_total++;
      if ({osc_v_in, peak_max, peak_min, period, busy, done, err, osc_rst} !== {8'd0, 8'd0, 8'd0, 11'd0, 4'b0001})
        $display("FAIL reset_outputs got vin=%0d max=%0d min=%0d per=%0d busy=%b done=%b err=%b osc_rst=%b",
                 osc_v_in, peak_max, peak_min, period, busy, done, err, osc_rst);
      else n_pass++;
    end
    rst = 1'b0;
    step();
    n_total++;
    if ({osc_rst, busy, done} !== 3'b000)
      $display("FAIL reset_release got osc_rst=%b busy=%b done=%b want 000", osc_rst, busy, done);
    else n_pass++;
    exp_vin = '0;
  endtask

  task automatic test_square();
    for (int i = 0; i < WIN; i++) pat[i] = ((i / 10) % 2) ? 8'd255 : 8'd0;
    run("square", 8'd64, -1, -1, -1);
  endtask

  task automatic test_constant();
    for (int i = 0; i < WIN; i++) pat[i] = 8'd100;
    run("constant", 8'd17, -1, -1, -1);
  endtask

  task automatic test_third_crossing();
    for (int i = 0; i < WIN; i++) pat[i] = 8'd0;
    pat[5] = 8'd127; pat[6] = 8'd128;
    pat[30] = 8'd127; pat[31] = 8'd128;
    pat[50] = 8'd127; pat[51] = 8'd128;
    run("third_cross", 8'd200, -1, -1, -1);
  endtask

  task automatic test_start_ignored();
    for (int i = 0; i < WIN; i++) pat[i] = ((i / 7) % 2) ? 8'd180 : 8'd40;
    run("start_ignored", 8'd99, 10, 70, T_DONE);
    // Nothing may have been queued: stay idle with no second done.
    for (int k = 0; k < 5; k++) begin
      step();
      n_total++;
      if ({busy, done} !== 2'b00) $display("FAIL no_requeue k=%0d got busy=%b done=%b", k, busy, done);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 5; r++) begin
      int hi;
      hi = (r == 4) ? 127 : int'($urandom_range(130, 255));
      for (int i = 0; i < WIN; i++) pat[i] = 8'($urandom_range(0, hi));
      run("random", 8'($urandom), -1, -1, -1);
    end
  endtask

  task automatic test_rst_mid_measure();
    start = 1'b1; amp_code = 8'd77;
    step();
    start = 1'b0;
    for (int c = 1; c < 30; c++) begin
      osc_v_out = 8'($urandom);
      step();
    end
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      n_total++;
      if ({osc_v_in, peak_max, peak_min, period, busy, done, err, osc_rst} !== {8'd0, 8'd0, 8'd0, 11'd0, 4'b0001})
        $display("FAIL rst_mid outputs got vin=%0d max=%0d min=%0d per=%0d busy=%b done=%b err=%b osc_rst=%b",
                 osc_v_in, peak_max, peak_min, period, busy, done, err, osc_rst);
      else n_pass++;
    end
    rst = 1'b0;
    step();
    n_total++;
    if ({osc_rst, busy} !== 2'b00) $display("FAIL rst_mid release got osc_rst=%b busy=%b", osc_rst, busy);
    else n_pass++;
    exp_vin = '0;
    for (int i = 0; i < WIN; i++) pat[i] = ((i / 10) % 2) ? 8'd255 : 8'd0;
    run("after_rst", 8'd64, -1, -1, -1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < WIN; i++) pat[i] = ((i / 5) % 2) ? 8'd200 : 8'd10;
    run("b2b_a", 8'd3, -1, -1, -1);
    for (int i = 0; i < WIN; i++) pat[i] = ((i / 12) % 2) ? 8'd129 : 8'd127;
    run("b2b_b", 8'd250, -1, -1, -1);
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_square();
    test_constant();
    test_third_crossing();
    test_start_ignored();
    test_random();
    test_rst_mid_measure();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sine_measure_ctrl.md
SINE_MEASURE_CTRL -- requirements
Module: sine_measure_ctrl

Interface
REQ-001 The block SHALL have parameter RST_CYCLES, default 2: number of cycles osc_rst is held high.
REQ-002 The block SHALL have parameter SETTLE_CYCLES, default 256: number of post-reset cycles ignored before measuring.
REQ-003 The block SHALL have parameter WINDOW, default 1792: length of the measurement window in cycles (1..2047).
REQ-004 The block SHALL have parameter MID, default 128: crossing threshold code.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port start, input, 1 bit: request one measurement run.
REQ-008 The block SHALL have port amp_code, input, 8 bits: oscillator input code, latched on start acceptance.
REQ-009 The block SHALL have port osc_v_in, output, 8 bits: drives the oscillator model v_in.
REQ-010 The block SHALL have port osc_rst, output, 1 bit: drives the oscillator model rst.
REQ-011 The block SHALL have port osc_v_out, input, 8 bits: oscillator model output sample.
REQ-012 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-014 The block SHALL have port err, output, 1 bit: fewer than 2 rising crossings were seen in the window.
REQ-015 The block SHALL have port peak_max, output, 8 bits: maximum sample in the window.
REQ-016 The block SHALL have port peak_min, output, 8 bits: minimum sample in the window.
REQ-017 The block SHALL have port period, output, 11 bits: cycles between the first and second rising crossings.

Function
REQ-018 The FSM SHALL have the states IDLE, OSC_RST, SETTLE, MEASURE and DONE.
REQ-019 In IDLE, start=1 SHALL be accepted: amp_code is latched to osc_v_in, err/peak_max/peak_min/period are cleared, and the next state is OSC_RST.
REQ-020 osc_rst SHALL be 1 for exactly RST_CYCLES cycles, in OSC_RST only, and the FSM SHALL then go to SETTLE.
REQ-021 SETTLE SHALL last exactly SETTLE_CYCLES cycles, with samples ignored; SETTLE_CYCLES=0 SHALL go directly to MEASURE.
REQ-022 MEASURE SHALL last exactly WINDOW cycles and sample osc_v_out once per cycle.
REQ-023 The first MEASURE sample SHALL initialise peak_max, peak_min and the previous-sample register, and SHALL NOT count as a crossing.
REQ-024 A rising crossing SHALL be prev < MID and cur >= MID, where the comparisons are unsigned.
REQ-025 The MEASURE cycle index SHALL be recorded (11-bit) at the first crossing; at the second crossing, period SHALL be set to index minus recorded index.
REQ-026 Later crossings SHALL be ignored, and the window SHALL always run to completion.
REQ-027 After MEASURE, err SHALL be 1 if fewer than 2 crossings were seen, and period SHALL then be 0.
REQ-028 In DONE, done SHALL be 1 for one cycle, and the FSM SHALL then go to IDLE.
REQ-029 Latency SHALL be: start accepted in cycle t gives done=1 in cycle t+1+RST_CYCLES+SETTLE_CYCLES+WINDOW.
REQ-030 start SHALL be ignored while busy=1, and start during DONE SHALL NOT be queued.
REQ-031 Results SHALL hold their values from DONE until the next accepted start.
REQ-032 osc_v_in SHALL hold its latched value until the next accepted start.

Reset
REQ-033 When rst=1 at a clock edge, the state SHALL become IDLE from any state, including mid-MEASURE, with any partial results discarded.
REQ-034 When rst=1 at a clock edge, osc_v_in, peak_max, peak_min, period, busy, done and err SHALL all be 0.
REQ-035 osc_rst SHALL be 1 while rst=1, so the oscillator is reset together with the controller, and SHALL be 0 afterwards until OSC_RST.

Verification (bench parameters RST_CYCLES=2, SETTLE_CYCLES=4, WINDOW=64, MID=128)
REQ-036 The bench SHALL apply start in cycle 0 with amp_code=64, and check osc_v_in=64 from cycle 1, osc_rst=1 in cycles 1-2, and done=1 only in cycle 71.
REQ-037 The bench SHALL drive a stub square wave on osc_v_out alternating 0 and 255 every 10 cycles, and check period=20, peak_max=255, peak_min=0 and err=0.
REQ-038 The bench SHALL drive osc_v_out constant at 100, and check err=1, period=0, peak_max=100 and peak_min=100.
REQ-039 The bench SHALL drive osc_v_out as 127 then 128 at MEASURE indexes 5/6, 127/128 at 30/31, and 127/128 at 50/51, and check period=25 (third crossing ignored).
REQ-040 The bench SHALL pulse start at cycles 10 and 70 of a busy run, and check that no second run starts: busy=0 in cycle 72 and done appears once.
REQ-041 The bench SHALL assert rst during MEASURE, and check that all outputs are 0 and osc_rst=1 while rst=1; a subsequent start SHALL give a full-length run with correct results.
